// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

    localparam int unsigned MIN_CLK_PER_BIT = 4;

    // Width of the data-bit index; never narrower than one bit.
    function automatic int unsigned bit_idx_width(input int unsigned datasize);
        return (datasize > 1) ? $clog2(datasize) : 1;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive word FIFO, first-word-fall-through, any depth (pointers wrap explicitly).
module uart_rx_fifo #(
    parameter int unsigned DATASIZE = 20,
    parameter int unsigned FIFOSIZE = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                push,
    input  logic [DATASIZE-1:0] push_data,
    input  logic                pop,
    output logic [DATASIZE-1:0] head,
    output logic                empty,
    output logic                full
);

    localparam int unsigned PW = (FIFOSIZE > 1) ? $clog2(FIFOSIZE) : 1;
    localparam int unsigned CW = $clog2(FIFOSIZE + 1);

    logic [DATASIZE-1:0] mem [FIFOSIZE];
    logic [PW-1:0]       wr_ptr;
    logic [PW-1:0]       rd_ptr;
    logic [CW-1:0]       count;
    logic                do_push;
    logic                do_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(FIFOSIZE - 1)) ? '0 : p + PW'(1);
    endfunction

    // push and pop are single-cycle strobes with no back-pressure: a push is
    // taken when not full or when a pop lands the same cycle; a pop on empty is dropped.
    assign empty   = (count == '0);
    assign full    = (count == CW'(FIFOSIZE));
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: synchroniser, frame FSM, sticky error flags and receive FIFO.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int unsigned DATASIZE = 20,
    parameter int unsigned FIFOSIZE = 10
) (
    input  logic                avl_clk_i,
    input  logic                avl_reset_i,
    input  logic                rx_i,
    input  logic [31:0]         clk_per_bit_i,
    output logic [DATASIZE-1:0] rx_data_o,
    output logic                rx_avail_o,
    output logic                rx_full_o,
    input  logic                rx_pop_i,
    output logic                overrun_o,
    output logic                frame_err_o,
    input  logic                clear_err_i,
    output rx_state_t           rx_state_o
);

    localparam int unsigned BW = bit_idx_width(DATASIZE);

    rx_state_t           state_q, state_d;
    logic [1:0]          sync_q;
    logic                prev_q;
    logic [31:0]         period_q;
    logic [31:0]         cnt_q;
    logic [BW-1:0]       bit_idx_q;
    logic [DATASIZE-1:0] shift_q;
    logic                overrun_q, ferr_q;
    logic                rxs, falling, last_bit;
    logic                start_sample, data_sample, stop_sample;
    logic                push, overrun_set, ferr_set;
    logic                fifo_empty, fifo_full;

    assign rxs      = sync_q[1];
    assign falling  = prev_q && !rxs;
    assign last_bit = (bit_idx_q == BW'(DATASIZE - 1));

    always_ff @(posedge avl_clk_i or posedge avl_reset_i) begin
        if (avl_reset_i) state_q <= IDLE;
        else             state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (falling) state_d = START;
            START:   if (start_sample) state_d = rxs ? IDLE : DATA;
            DATA:    if (data_sample && last_bit) state_d = STOP;
            STOP:    if (stop_sample) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        start_sample = 1'b0;
        data_sample  = 1'b0;
        stop_sample  = 1'b0;
        case (state_q)
            START:   start_sample = (cnt_q == (period_q >> 1));
            DATA:    data_sample  = (cnt_q == period_q - 32'd1);
            STOP:    stop_sample  = (cnt_q == period_q - 32'd1);
            default: ;
        endcase
        push        = stop_sample && rxs && (!fifo_full || rx_pop_i);
        overrun_set = stop_sample && rxs && fifo_full && !rx_pop_i;
        ferr_set    = stop_sample && !rxs;
    end

    // Idle-high reset of the synchroniser keeps reset release from looking like a start edge.
    always_ff @(posedge avl_clk_i or posedge avl_reset_i) begin
        if (avl_reset_i) begin
            sync_q    <= 2'b11;
            prev_q    <= 1'b1;
            period_q  <= '0;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            overrun_q <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], rx_i};
            prev_q <= rxs;
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (falling)
                        period_q <= (clk_per_bit_i < 32'(MIN_CLK_PER_BIT)) ?
                                    32'(MIN_CLK_PER_BIT) : clk_per_bit_i;
                end
                START: begin
                    if (start_sample) begin
                        cnt_q     <= '0;
                        bit_idx_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                DATA: begin
                    if (data_sample) begin
                        cnt_q     <= '0;
                        bit_idx_q <= bit_idx_q + BW'(1);
                        shift_q   <= {rxs, shift_q[DATASIZE-1:1]};
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                STOP:    cnt_q <= stop_sample ? '0 : cnt_q + 32'd1;
                default: cnt_q <= '0;
            endcase
            overrun_q <= overrun_set | (overrun_q & ~clear_err_i);
            ferr_q    <= ferr_set | (ferr_q & ~clear_err_i);
        end
    end

    uart_rx_fifo #(
        .DATASIZE (DATASIZE),
        .FIFOSIZE (FIFOSIZE)
    ) u_fifo (
        .clk       (avl_clk_i),
        .rst       (avl_reset_i),
        .push      (push),
        .push_data (shift_q),
        .pop       (rx_pop_i),
        .head      (rx_data_o),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign rx_avail_o  = !fifo_empty;
    assign rx_full_o   = fifo_full;
    assign overrun_o   = overrun_q;
    assign frame_err_o = ferr_q;
    assign rx_state_o  = state_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core against a queue-based model of the receive path.
module tb_uart_rx_core;
    import uart_pkg::*;

    localparam int DW = 20;
    localparam int FS = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rx = 1'b1;
    logic [31:0]   cpb = 32'd8;
    logic          pop = 1'b0;
    logic          clr = 1'b0;
    logic [DW-1:0] rx_data;
    logic          avail, full, ovr, ferr;
    rx_state_t     st;

    int            n_checks = 0;
    int            n_fail = 0;
    int            rises = 0;
    logic          avail_prev = 1'b0;

    // Model: FIFO contents and sticky flags derived from the frame rules.
    logic [DW-1:0] exp_q[$];
    logic          exp_ovr = 1'b0;
    logic          exp_ferr = 1'b0;

    uart_rx_core #(.DATASIZE(DW), .FIFOSIZE(FS)) dut (
        .avl_clk_i     (clk),
        .avl_reset_i   (rst),
        .rx_i          (rx),
        .clk_per_bit_i (cpb),
        .rx_data_o     (rx_data),
        .rx_avail_o    (avail),
        .rx_full_o     (full),
        .rx_pop_i      (pop),
        .overrun_o     (ovr),
        .frame_err_o   (ferr),
        .clear_err_i   (clr),
        .rx_state_o    (st)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (avail && !avail_prev) rises++;
        avail_prev <= avail;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic send_frame(input logic [DW-1:0] w, input int p, input logic stop_bit);
        cpb = 32'(p);
        @(posedge clk); #1 rx = 1'b0;
        repeat (p) @(posedge clk);
        for (int i = 0; i < DW; i++) begin
            #1 rx = w[i];
            repeat (p) @(posedge clk);
        end
        #1 rx = stop_bit;
        repeat (p) @(posedge clk);
        #1 rx = 1'b1;
        repeat (3 * p + 4) @(posedge clk);
        #1;
    endtask

    task automatic model_frame(input logic [DW-1:0] w, input logic stop_bit, input logic pop_same);
        if (!stop_bit) exp_ferr = 1'b1;
        else if (exp_q.size() < FS || pop_same) begin
            if (pop_same && exp_q.size() > 0) void'(exp_q.pop_front());
            exp_q.push_back(w);
        end else exp_ovr = 1'b1;
    endtask

    task automatic pulse_pop();
        pop = 1'b1;
        @(posedge clk); #1 pop = 1'b0;
    endtask

    task automatic pulse_clear();
        clr = 1'b1;
        @(posedge clk); #1 clr = 1'b0;
        exp_ovr = 1'b0;
        exp_ferr = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({avail, full, ovr, ferr} !== 4'b0000 || rx_data !== '0) begin
            n_fail++;
            $display("FAIL reset_hold: avail=%b full=%b ovr=%b ferr=%b data=%h, want all 0", avail, full, ovr, ferr, rx_data);
        end
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (st !== IDLE || avail !== 1'b0 || rx_data !== '0) begin
            n_fail++;
            $display("FAIL reset_release: state=%0d avail=%b data=%h, want IDLE/0/0", st, avail, rx_data);
        end
    endtask

    task automatic test_single_frame();
        int lat = -1;
        int r0 = rises;
        logic [DW-1:0] w = 20'hA5A5A;
        fork
            send_frame(w, 8, 1'b1);
            begin
                @(posedge clk); #1;
                for (int n = 1; n <= 400; n++) begin
                    @(posedge clk); #1;
                    if (avail) begin lat = n; break; end
                end
            end
        join
        model_frame(w, 1'b1, 1'b0);
        // start edge -> avail: 2 + P/2 + (DW+1)*P + 1, one cycle of synchroniser slack
        n_checks++;
        if (lat < 174 || lat > 176) begin
            n_fail++;
            $display("FAIL single_latency: got %0d cycles, want 174..176", lat);
        end
        n_checks++;
        if (rises - r0 !== 1) begin
            n_fail++;
            $display("FAIL single_rises: avail rose %0d times, want 1", rises - r0);
        end
        n_checks++;
        if (avail !== 1'b1 || rx_data !== exp_q[0] || full !== 1'b0 || ovr !== 1'b0 || ferr !== 1'b0) begin
            n_fail++;
            $display("FAIL single_status: avail=%b data=%h full=%b ovr=%b ferr=%b, want 1/%h/0/0/0", avail, rx_data, full, ovr, ferr, exp_q[0]);
        end
        pulse_pop();
        void'(exp_q.pop_front());
        n_checks++;
        if (avail !== 1'b0 || rx_data !== '0) begin
            n_fail++;
            $display("FAIL single_pop: avail=%b data=%h, want 0/0", avail, rx_data);
        end
    endtask

    task automatic test_glitch();
        cpb = 32'd8;
        @(posedge clk); #1 rx = 1'b0;
        repeat (3) @(posedge clk);
        #1 rx = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (st !== START) begin
            n_fail++;
            $display("FAIL glitch_start: state=%0d, want START", st);
        end
        repeat (10) @(posedge clk);
        #1;
        n_checks++;
        if (st !== IDLE || avail !== 1'b0 || ovr !== 1'b0 || ferr !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch_idle: state=%0d avail=%b ovr=%b ferr=%b, want IDLE/0/0/0", st, avail, ovr, ferr);
        end
    endtask

    task automatic test_frame_error();
        send_frame(20'h00001, 8, 1'b0);
        model_frame(20'h00001, 1'b0, 1'b0);
        n_checks++;
        if (ferr !== exp_ferr || avail !== 1'b0) begin
            n_fail++;
            $display("FAIL ferr_set: ferr=%b avail=%b, want %b/0", ferr, avail, exp_ferr);
        end
        pulse_clear();
        n_checks++;
        if (ferr !== 1'b0) begin
            n_fail++;
            $display("FAIL ferr_clear: ferr=%b, want 0", ferr);
        end
        send_frame(20'h00002, 8, 1'b1);
        model_frame(20'h00002, 1'b1, 1'b0);
        n_checks++;
        if (avail !== 1'b1 || rx_data !== 20'h00002 || ferr !== 1'b0) begin
            n_fail++;
            $display("FAIL ferr_recover: avail=%b data=%h ferr=%b, want 1/00002/0", avail, rx_data, ferr);
        end
        pulse_pop();
        void'(exp_q.pop_front());
    endtask

    task automatic test_overrun();
        for (int v = 1; v <= 11; v++) begin
            send_frame(DW'(v), 4, 1'b1);
            model_frame(DW'(v), 1'b1, 1'b0);
            n_checks++;
            if (full !== (exp_q.size() == FS) || ovr !== exp_ovr || avail !== 1'b1) begin
                n_fail++;
                $display("FAIL overrun_frame%0d: full=%b ovr=%b avail=%b, want %b/%b/1", v, full, ovr, avail, exp_q.size() == FS, exp_ovr);
            end
        end
    endtask

    task automatic test_pop_on_stop();
        pulse_clear();
        n_checks++;
        if (ovr !== 1'b0) begin
            n_fail++;
            $display("FAIL pos_clear: ovr=%b, want 0", ovr);
        end
        // P=4: the stop bit is sampled 89 cycles after the start edge
        fork
            send_frame(20'd12, 4, 1'b1);
            begin
                repeat (89) @(posedge clk);
                #1;
                n_checks++;
                if (rx_data !== exp_q[0]) begin
                    n_fail++;
                    $display("FAIL pos_head: data=%h, want %h", rx_data, exp_q[0]);
                end
                pulse_pop();
            end
        join
        model_frame(20'd12, 1'b1, 1'b1);
        n_checks++;
        if (ovr !== exp_ovr || full !== 1'b1 || rx_data !== exp_q[0]) begin
            n_fail++;
            $display("FAIL pos_status: ovr=%b full=%b data=%h, want %b/1/%h", ovr, full, rx_data, exp_ovr, exp_q[0]);
        end
    endtask

    task automatic test_drain();
        int n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            n_checks++;
            if (avail !== 1'b1 || rx_data !== exp_q[0]) begin
                n_fail++;
                $display("FAIL drain_word%0d: avail=%b data=%h, want 1/%h", i, avail, rx_data, exp_q[0]);
            end
            pulse_pop();
            void'(exp_q.pop_front());
        end
        pulse_pop();
        n_checks++;
        if (avail !== 1'b0 || full !== 1'b0 || rx_data !== '0) begin
            n_fail++;
            $display("FAIL drain_empty: avail=%b full=%b data=%h, want 0/0/0", avail, full, rx_data);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [DW-1:0] w = DW'($urandom);
        send_frame(w, 8, 1'b1);
        model_frame(w, 1'b1, 1'b0);
        send_frame(20'h00003, 8, 1'b0);
        model_frame(20'h00003, 1'b0, 1'b0);
        fork
            send_frame(20'hFFFFF, 8, 1'b1);
            begin
                repeat (100) @(posedge clk);
                #1 rst = 1'b1;
                #1;
                n_checks++;
                if ({avail, full, ovr, ferr} !== 4'b0000 || rx_data !== '0 || st !== IDLE) begin
                    n_fail++;
                    $display("FAIL midreset_outputs: avail=%b full=%b ovr=%b ferr=%b data=%h state=%0d, want all 0/IDLE", avail, full, ovr, ferr, rx_data, st);
                end
                @(posedge clk); #1 rst = 1'b0;
            end
        join
        exp_q.delete();
        exp_ovr = 1'b0;
        exp_ferr = 1'b0;
        n_checks++;
        if (avail !== 1'b0 || ferr !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_nopush: avail=%b ferr=%b, want 0/0", avail, ferr);
        end
        send_frame(20'hFFFFF, 8, 1'b1);
        model_frame(20'hFFFFF, 1'b1, 1'b0);
        n_checks++;
        if (avail !== 1'b1 || rx_data !== 20'hFFFFF) begin
            n_fail++;
            $display("FAIL midreset_next: avail=%b data=%h, want 1/fffff", avail, rx_data);
        end
        pulse_pop();
        void'(exp_q.pop_front());
    endtask

    task automatic test_random();
        for (int f = 0; f < 8; f++) begin
            logic [DW-1:0] w = DW'($urandom);
            int p = $urandom_range(4, 10);
            logic sb = ($urandom_range(0, 4) != 0);
            int npop = $urandom_range(0, 2);
            send_frame(w, p, sb);
            model_frame(w, sb, 1'b0);
            n_checks++;
            if (avail !== (exp_q.size() > 0) || full !== (exp_q.size() == FS) || ovr !== exp_ovr || ferr !== exp_ferr) begin
                n_fail++;
                $display("FAIL rand_status%0d: avail=%b full=%b ovr=%b ferr=%b, want %b/%b/%b/%b", f, avail, full, ovr, ferr, exp_q.size() > 0, exp_q.size() == FS, exp_ovr, exp_ferr);
            end
            for (int k = 0; k < npop; k++) begin
                logic [DW-1:0] want = (exp_q.size() > 0) ? exp_q[0] : '0;
                n_checks++;
                if (rx_data !== want) begin
                    n_fail++;
                    $display("FAIL rand_head%0d_%0d: data=%h, want %h", f, k, rx_data, want);
                end
                pulse_pop();
                if (exp_q.size() > 0) void'(exp_q.pop_front());
            end
        end
        pulse_clear();
        n_checks++;
        if (ovr !== 1'b0 || ferr !== 1'b0) begin
            n_fail++;
            $display("FAIL rand_clear: ovr=%b ferr=%b, want 0/0", ovr, ferr);
        end
        test_drain();
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_glitch();
        test_frame_error();
        test_overrun();
        test_pop_on_stop();
        test_drain();
        test_reset_mid_frame();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
